saf_ctrl: RTL and testbench
===========================

Name: saf_ctrl

Overview:
- Sequencer for one sliding-average filter instance: applies the sample-interval configuration, flushes the filter, waits out the window-fill, then forwards settled averages to a downstream consumer over a valid/ready handshake.
- Sits between the register/control interface and the filter output in the measurement chain.
- Detects a filter that produces no output (timeout) and a consumer that is too slow (overrun).

Parameters:
- WINDOW_WIDTH, 10, log2 of filter window length; must match the controlled filter.
- DATA_WIDTH, 16, filter data width.
- FLUSH_CYCLES, 2, cycles flt_rst is held high per flush; minimum 1.
- SKIP_VALIDS, 1, number of first filter outputs discarded after a flush.
- TIMEOUT_CYCLES, 2**20, maximum cycles in FILL without a filter output.

Ports:
- clk, in, 1, system clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, pulse: begin measurement.
- stop, in, 1, pulse: end measurement and return to IDLE.
- cfg_interval, in, 8, requested sample interval.
- cfg_wr, in, 1, pulse: cfg_interval is valid.
- flt_rst, out, 1, active-high synchronous reset to the filter.
- flt_interval, out, 8, interval driven to the filter.
- flt_valid, in, 1, filter output valid.
- flt_data, in, DATA_WIDTH, filter output (signed).
- m_valid, out, 1, measurement valid.
- m_ready, in, 1, consumer ready.
- m_data, out, DATA_WIDTH, measurement.
- busy, out, 1, high whenever state is not IDLE.
- settled, out, 1, high only in RUN.
- err_timeout, out, 1, sticky timeout flag.
- err_overrun, out, 1, sticky overrun flag.
- err_clr, in, 1, pulse: clears both sticky flags.

Behaviour:
- Reset values:
  - State IDLE; flt_rst=1; flt_interval=1; shadow interval=1.
  - m_valid=0, m_data=0, busy=0, settled=0, both error flags 0.
- Configuration:
  - cfg_wr latches a shadow register; cfg_interval=0 is stored as 1.
  - flt_interval updates from the shadow only on FLUSH entry, never mid-run.
- IDLE: flt_rst=1. start moves to FLUSH. If start and stop arrive in the same cycle, stop wins and the state stays IDLE.
- FLUSH:
  - flt_rst=1 for exactly FLUSH_CYCLES cycles, then move to FILL.
  - Entry clears the skip counter, the timeout counter and the output holding register (m_valid=0).
- FILL:
  - flt_rst=0.
  - Each flt_valid decrements the skip counter; those flt_valid are discarded.
  - The cycle after the SKIP_VALIDS-th flt_valid, move to RUN.
  - The timeout counter increments each cycle and resets on flt_valid. Reaching TIMEOUT_CYCLES sets err_timeout and moves to IDLE.
- RUN:
  - settled=1.
  - flt_valid loads flt_data into the holding register with m_valid=1 on the next cycle.
  - m_valid stays high with m_data stable until m_valid && m_ready.
  - If flt_valid arrives while m_valid=1 and m_ready=0: new data overwrites, err_overrun=1, m_valid stays 1.
  - If flt_valid arrives in the same cycle as a handshake: load with no overrun.
- Re-sequencing:
  - cfg_wr in FILL or RUN with a value different from the current flt_interval moves to FLUSH next cycle. An equal value is ignored.
  - stop in any non-IDLE state moves to IDLE next cycle and drops m_valid.
  - Priority: stop > cfg_wr > start > flt_valid.
- Errors: err_clr clears both flags. If err_clr and a set event occur in the same cycle, set wins.
- Latency: start to first m_valid = 1 + FLUSH_CYCLES + fill time + 1 cycle.
- Widths: flt_data passes through unmodified. Counters are sized with $clog2; the timeout counter saturates.
- Asynchronous reset mid-operation returns every register to its reset value immediately.

Decomposition:
- Package saf_ctrl_pkg:
  - State enum: IDLE, FLUSH, FILL, RUN.
  - Constants: FLUSH_CYCLES default, minimum interval (1), and counter-width functions.
- Sub-module saf_out_hold: single-entry valid/ready holding register with overrun detection.
- FSM and counters stay in the top level.

Test Plan:
- Bench uses WINDOW_WIDTH=3 with a filter model emitting flt_valid every 4 cycles, and FLUSH_CYCLES=2.
  - cfg 5, start: flt_rst high exactly 2 cycles, flt_interval=5.
  - First flt_valid is dropped; the second (data 0x0123) appears as m_data=0x0123 with m_valid.
- cfg_wr of 0 then start -> flt_interval=1.
  - cfg_wr 3 during RUN -> FLUSH, settled drops next cycle, flt_interval=3.
  - A repeated cfg_wr 3 in RUN causes no flush.
- m_ready=0 in RUN with data 0x0010 then 0x0020 -> err_overrun=1, m_data=0x0020.
  - err_clr clears it; handshake and flt_valid in the same cycle -> no overrun.
- TIMEOUT_CYCLES=50, filter model silent -> 50 cycles after FILL entry err_timeout=1, state IDLE, busy=0, flt_rst=1.
- rst_n low asynchronously mid-RUN with m_valid=1 -> all outputs return to reset values before the next clk edge.
  - start and stop in the same cycle -> remains IDLE.

Source files
------------

// File: rtl/saf_ctrl_pkg.sv
// rtl/saf_ctrl_pkg.sv - shared types and constants for the sliding-average filter sequencer
package saf_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    FILL  = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int         FLUSH_CYCLES_DEF = 2;
  localparam logic [7:0] MIN_INTERVAL     = 8'd1;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/saf_out_hold.sv
// rtl/saf_out_hold.sv - single-entry valid/ready holding register with overrun detection
module saf_out_hold #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  m_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  overrun
);

  // A load that coincides with a handshake replaces the consumed entry cleanly.
  assign overrun = load && m_valid && !m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (clr) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
    end else if (m_valid && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/saf_ctrl.sv
// rtl/saf_ctrl.sv - sequencer for one sliding-average filter: configure, flush, fill, forward
module saf_ctrl
  import saf_ctrl_pkg::*;
#(
  parameter int WINDOW_WIDTH   = 10,
  parameter int DATA_WIDTH     = 16,
  parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
  parameter int SKIP_VALIDS    = 1,
  parameter int TIMEOUT_CYCLES = 2**20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [7:0]            cfg_interval,
  input  logic                  cfg_wr,
  output logic                  flt_rst,
  output logic [7:0]            flt_interval,
  input  logic                  flt_valid,
  input  logic [DATA_WIDTH-1:0] flt_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  settled,
  output logic                  err_timeout,
  output logic                  err_overrun,
  input  logic                  err_clr
);

  // Timeout counter is wide enough for a full window fill at the longest interval.
  localparam int FILL_SPAN = (1 << WINDOW_WIDTH) * 255;
  localparam int TO_SPAN   = (TIMEOUT_CYCLES > FILL_SPAN) ? TIMEOUT_CYCLES : FILL_SPAN;
  localparam int FL_W      = cnt_w(FLUSH_CYCLES);
  localparam int SK_W      = cnt_w(SKIP_VALIDS);
  localparam int TO_W      = cnt_w(TO_SPAN);

  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLUSH_CYCLES - 1);
  localparam logic [SK_W-1:0] SK_LAST = SK_W'(SKIP_VALIDS - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_t          state, state_nxt;
  logic [7:0]      shadow, shadow_nxt, cfg_san;
  logic [FL_W-1:0] flush_cnt;
  logic [SK_W-1:0] skip_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            cfg_diff, skip_done, timeout_hit, to_evt;
  logic            enter_flush, to_idle, hold_clr, hold_load, overrun;

  always_comb begin
    cfg_san     = (cfg_interval == 8'd0) ? MIN_INTERVAL : cfg_interval;
    shadow_nxt  = cfg_wr ? cfg_san : shadow;
    cfg_diff    = cfg_wr && (cfg_san != flt_interval);
    skip_done   = (SKIP_VALIDS == 0) || (flt_valid && (skip_cnt == SK_LAST));
    timeout_hit = !flt_valid && (to_cnt == TO_LAST);
    to_evt      = 1'b0;
    state_nxt   = state;
    case (state)
      IDLE: begin
        if (start && !stop) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (stop)                        state_nxt = IDLE;
        else if (flush_cnt == FL_LAST)   state_nxt = FILL;
      end
      FILL: begin
        if (stop)           state_nxt = IDLE;
        else if (cfg_diff)  state_nxt = FLUSH;
        else if (skip_done) state_nxt = RUN;
        else if (timeout_hit) begin
          state_nxt = IDLE;
          to_evt    = 1'b1;
        end
      end
      RUN: begin
        if (stop)          state_nxt = IDLE;
        else if (cfg_diff) state_nxt = FLUSH;
      end
      default: state_nxt = IDLE;
    endcase
    enter_flush = (state_nxt == FLUSH) && (state != FLUSH);
    to_idle     = (state_nxt == IDLE) && (state != IDLE);
    hold_clr    = enter_flush || to_idle;
    hold_load   = (state == RUN) && (state_nxt == RUN) && flt_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shadow       <= MIN_INTERVAL;
      flt_interval <= MIN_INTERVAL;
      flush_cnt    <= '0;
      skip_cnt     <= '0;
      to_cnt       <= '0;
      err_timeout  <= 1'b0;
      err_overrun  <= 1'b0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      if (enter_flush) begin
        flt_interval <= shadow_nxt;
        flush_cnt    <= '0;
        skip_cnt     <= '0;
        to_cnt       <= '0;
      end else begin
        if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
        if (state == FILL && flt_valid) skip_cnt <= skip_cnt + 1'b1;
        if (state == FILL) begin
          if (flt_valid)         to_cnt <= '0;
          else if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
        end
      end
      if (to_evt)       err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
      if (overrun)      err_overrun <= 1'b1;
      else if (err_clr) err_overrun <= 1'b0;
    end
  end

  assign flt_rst = (state == IDLE) || (state == FLUSH);
  assign busy    = (state != IDLE);
  assign settled = (state == RUN);

  saf_out_hold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (hold_clr),
    .load      (hold_load),
    .load_data (flt_data),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .overrun   (overrun)
  );

endmodule

// File: tb/tb_saf_ctrl.sv
// tb/tb_saf_ctrl.sv - self-checking bench for saf_ctrl with a behavioural reference model
module tb_saf_ctrl;

  localparam int FLUSH_N   = 2;
  localparam int SKIP_N    = 1;
  localparam int TIMEOUT_N = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, cfg_wr = 1'b0, err_clr = 1'b0;
  logic [7:0]  cfg_interval = 8'd0;
  logic        flt_rst;
  logic [7:0]  flt_interval;
  logic        flt_valid = 1'b0;
  logic [15:0] flt_data = 16'h0;
  logic        m_valid, m_ready = 1'b1;
  logic [15:0] m_data;
  logic        busy, settled, err_timeout, err_overrun;

  int total = 0;
  int bad = 0;

  saf_ctrl #(
    .WINDOW_WIDTH(3), .DATA_WIDTH(16), .FLUSH_CYCLES(FLUSH_N),
    .SKIP_VALIDS(SKIP_N), .TIMEOUT_CYCLES(TIMEOUT_N)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .cfg_interval(cfg_interval), .cfg_wr(cfg_wr),
    .flt_rst(flt_rst), .flt_interval(flt_interval),
    .flt_valid(flt_valid), .flt_data(flt_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .settled(settled),
    .err_timeout(err_timeout), .err_overrun(err_overrun), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Filter stand-in: one output every 4 cycles while out of reset, data from a queue.
  logic [15:0] fq[$];
  logic        silent = 1'b0;
  int          fcnt = 0;
  always @(posedge clk) begin
    #2;
    flt_valid = 1'b0;
    if (flt_rst || silent) begin
      fcnt = 0;
    end else begin
      fcnt++;
      if (fcnt == 4) begin
        fcnt = 0;
        flt_valid = 1'b1;
        flt_data = (fq.size() > 0) ? fq.pop_front() : 16'h0000;
      end
    end
  end

  // Reference model: a measurement is active, with some flush cycles and some
  // discarded filter outputs still owed before averages are forwarded.
  bit          md_active;
  int          md_flush_left, md_drops_left, md_silent;
  logic [7:0]  md_shadow, md_int, md_san;
  bit          md_v, md_to, md_ov;
  logic [15:0] md_d;

  task automatic md_go_idle();
    md_active = 0; md_flush_left = 0; md_drops_left = 0;
    md_v = 0; md_d = 16'h0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_go_idle();
      md_silent = 0; md_shadow = 8'd1; md_int = 8'd1; md_to = 0; md_ov = 0;
    end else begin
      bit restart, to_evt, ov_evt;
      restart = 0; to_evt = 0; ov_evt = 0;
      md_san = (cfg_interval == 8'd0) ? 8'd1 : cfg_interval;
      if (cfg_wr) md_shadow = md_san;
      if (!md_active) begin
        if (start && !stop) restart = 1;
      end else if (stop) begin
        md_go_idle();
      end else if (md_flush_left > 0) begin
        md_flush_left--;
      end else if (cfg_wr && md_san != md_int) begin
        restart = 1;
      end else if (md_drops_left > 0) begin
        if (flt_valid) begin
          md_drops_left--;
          md_silent = 0;
        end else begin
          md_silent++;
          if (md_silent >= TIMEOUT_N) begin
            to_evt = 1;
            md_go_idle();
          end
        end
      end else begin
        if (flt_valid) begin
          if (md_v && !m_ready) ov_evt = 1;
          md_v = 1; md_d = flt_data;
        end else if (md_v && m_ready) begin
          md_v = 0;
        end
      end
      if (restart) begin
        md_active = 1; md_flush_left = FLUSH_N; md_drops_left = SKIP_N;
        md_silent = 0; md_v = 0; md_d = 16'h0; md_int = md_shadow;
      end
      if (err_clr) begin md_to = 0; md_ov = 0; end
      if (to_evt) md_to = 1;
      if (ov_evt) md_ov = 1;
    end
  end

  always @(negedge clk) begin
    logic [29:0] exp_v, got_v;
    bit run_now;
    run_now = md_active && md_flush_left == 0 && md_drops_left == 0;
    exp_v = {!(md_active && md_flush_left == 0), md_int, md_v, md_d,
             md_active, run_now, md_to, md_ov};
    got_v = {flt_rst, flt_interval, m_valid, m_data, busy, settled, err_timeout, err_overrun};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL model_cycle t=%0t got=%h exp=%h", $time, got_v, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic pulse_cfg(input logic [7:0] v);
    cfg_interval = v; cfg_wr = 1'b1; tick(); cfg_wr = 1'b0;
  endtask

  task automatic wait_settled(input string name);
    bit hit;
    hit = 0;
    for (int i = 0; i < 80; i++) begin
      if (settled) begin hit = 1; break; end
      tick();
    end
    check(name, hit, 1);
  endtask

  initial begin
    int  n;
    bit  hit;
    repeat (3) tick();
    check("rst_flt_rst", flt_rst, 1);
    check("rst_interval", flt_interval, 1);
    check("rst_busy", busy, 0);
    check("rst_m_valid", m_valid, 0);
    rst_n = 1'b1;
    tick();

    // cfg 5, start: two flush cycles, first filter output dropped
    fq.delete(); fq.push_back(16'h0999); fq.push_back(16'h0123);
    pulse_cfg(8'd5);
    start = 1'b1; tick(); start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy && flt_rst) n++; else break;
      tick();
    end
    check("flush_len", n, 2);
    check("interval_5", flt_interval, 5);
    hit = 0;
    for (int i = 0; i < 60; i++) begin
      if (m_valid) begin hit = 1; break; end
      tick();
    end
    check("first_m_valid", hit, 1);
    check("first_m_data", m_data, 16'h0123);

    // interval 0 maps to 1; reconfig in RUN reflushes, an equal value does not
    stop = 1'b1; tick(); stop = 1'b0;
    pulse_cfg(8'd0);
    start = 1'b1; tick(); start = 1'b0;
    wait_settled("settle_int1");
    check("interval_1", flt_interval, 1);
    pulse_cfg(8'd3);
    check("reflush_settled", settled, 0);
    check("reflush_busy", busy, 1);
    check("interval_3", flt_interval, 3);
    wait_settled("settle_int3");
    pulse_cfg(8'd3);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!settled) n++;
      tick();
    end
    check("same_cfg_no_flush", n, 0);

    // overrun with a stalled consumer
    m_ready = 1'b0;
    fq.delete(); fq.push_back(16'h0010); fq.push_back(16'h0020);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_valid && m_data == 16'h0020) begin hit = 1; break; end
      tick();
    end
    check("overrun_data_seen", hit, 1);
    check("overrun_flag", err_overrun, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("overrun_cleared", err_overrun, 0);

    // handshake and new filter output in the same cycle
    fq.push_back(16'h0030);
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      if (flt_valid) begin hit = 1; break; end
      tick();
    end
    check("flt_valid_seen", hit, 1);
    m_ready = 1'b1;
    tick();
    check("hs_load_valid", m_valid, 1);
    check("hs_load_data", m_data, 16'h0030);
    check("hs_no_overrun", err_overrun, 0);

    // silent filter: timeout 50 cycles after FILL entry
    stop = 1'b1; tick(); stop = 1'b0;
    silent = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy && !flt_rst) begin hit = 1; break; end
      tick();
    end
    check("fill_entry", hit, 1);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      if (err_timeout) break;
      tick();
      n++;
    end
    check("timeout_cycles", n, 50);
    check("timeout_busy", busy, 0);
    check("timeout_flt_rst", flt_rst, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    check("timeout_cleared", err_timeout, 0);
    silent = 1'b0;

    // asynchronous reset while a measurement is held
    m_ready = 1'b0;
    fq.delete(); fq.push_back(16'h0777); fq.push_back(16'h0abc);
    start = 1'b1; tick(); start = 1'b0;
    hit = 0;
    for (int i = 0; i < 80; i++) begin
      if (m_valid) begin hit = 1; break; end
      tick();
    end
    check("pre_reset_m_valid", hit, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_m_data", m_data, 0);
    check("arst_busy", busy, 0);
    check("arst_settled", settled, 0);
    check("arst_flt_rst", flt_rst, 1);
    check("arst_interval", flt_interval, 1);
    tick();
    rst_n = 1'b1;
    m_ready = 1'b1;
    tick();

    // start and stop together: stop wins
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("start_stop_busy", busy, 0);
    tick();
    check("start_stop_busy2", busy, 0);
    check("start_stop_flt_rst", flt_rst, 1);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
